gb_serial: RTL and testbench

Serial link port for the Game Boy SoC: owns the SB (0xFF01) and SC (0xFF02) I/O registers, shifts a byte out and in MSB-first on the internal or external shift clock, and raises a one-cycle serial interrupt request on completion. It sits on the CPU data bus next to `gb_timer`, decoding the same address/write-enable signals. It replaces the bench-level SB/SC memory hack. It exposes a byte-sniffer strobe so benches can print test-ROM serial output.

---
 rtl/gb_io_pkg.sv | 7 +
 rtl/gb_sync_edge.sv | 15 +
 rtl/gb_serial.sv | 72 +++++++
 tb/tb_gb_serial.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/gb_io_pkg.sv
// gb_io_pkg: shared I/O register addresses, serial FSM states and the serial IF bit
package gb_io_pkg;
   localparam logic [15:0] ADDR_SB = 16'hFF01;
   localparam logic [15:0] ADDR_SC = 16'hFF02;
   localparam int IRQ_SERIAL_BIT = 3;
   typedef enum logic {IDLE, SHIFT} serial_state_t;
endpackage

// File: rtl/gb_sync_edge.sv
// gb_sync_edge: 2-FF synchronizer with a one-cycle rising-edge pulse
// ports: clk, reset (sync, active-low), d (async in), rise (pulse, 3rd cycle after d rises)
module gb_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   // flops reset high so an idle-high input never produces a spurious edge
   logic [2:0] sh;
   always_ff @(posedge clk)
      if (!reset) sh <= 3'b111;
      else sh <= {sh[1:0], d};
   assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/gb_serial.sv
// gb_serial: SB/SC serial link port, MSB-first shift on internal or external clock
// ports: clk, reset (sync, active-low); CPU bus addr/data_i/wren/data_o;
//        link sin/sclk_ext/sout/sclk_out; irq_serial; sniffer tx_strobe/tx_data
module gb_serial
   import gb_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  data_i,
   input  logic        wren,
   output logic [7:0]  data_o,
   input  logic        sin,
   input  logic        sclk_ext,
   output logic        sout,
   output logic        sclk_out,
   output logic        irq_serial,
   output logic        tx_strobe,
   output logic [7:0]  tx_data
);
   localparam int DW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   serial_state_t state_q, state_d;
   logic [7:0] sb_q;
   logic int_q, out_q, ext_rise;
   logic [DW-1:0] div_q;
   logic [2:0] cnt_q;
   logic sb_wr, sc_wr, start, stop, shift, last, busy;
   gb_sync_edge u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (sclk_ext),
      .rise (ext_rise)
   );
   assign busy  = state_q == SHIFT;
   assign sb_wr = wren && addr == ADDR_SB;
   assign sc_wr = wren && addr == ADDR_SC;
   assign start = sc_wr && data_i[7];
   assign stop  = sc_wr && !data_i[7];
   // any SC write on a shift edge takes priority over that shift
   assign shift = busy && !sc_wr && (int_q ? div_q == DW'(CLKS_PER_BIT - 1) : ext_rise);
   assign last  = shift && cnt_q == 3'd7;
   always_comb
      state_d = start ? SHIFT : (stop || last) ? IDLE : state_q;
   always_ff @(posedge clk)
      if (!reset) begin
         state_q    <= IDLE;
         sb_q       <= 8'h00;
         int_q      <= 1'b0;
         div_q      <= '0;
         cnt_q      <= 3'd0;
         out_q      <= 1'b1;
         irq_serial <= 1'b0;
         tx_strobe  <= 1'b0;
         tx_data    <= 8'h00;
      end else begin
         state_q    <= state_d;
         if (sc_wr) int_q <= data_i[0];
         div_q      <= (start || shift || !busy || !int_q) ? '0 : div_q + 1'b1;
         cnt_q      <= start ? 3'd0 : shift ? cnt_q + 3'd1 : cnt_q;
         sb_q       <= sb_wr ? data_i : shift ? {sb_q[6:0], sin} : sb_q;
         // remembers the last bit driven so sout holds it once the transfer ends
         out_q      <= start ? 1'b1 : shift ? sb_q[7] : out_q;
         irq_serial <= last;
         tx_strobe  <= start;
         if (start) tx_data <= sb_q;
      end
   assign sout     = busy ? sb_q[7] : out_q;
   assign sclk_out = !(busy && int_q && div_q < DW'(CLKS_PER_BIT / 2));
   assign data_o   = addr == ADDR_SB ? sb_q : addr == ADDR_SC ? {busy, 6'h3F, int_q} : 8'hFF;
endmodule

// File: tb/tb_gb_serial.sv
// tb_gb_serial: directed self-checking bench for gb_serial with CLKS_PER_BIT=4
module tb_gb_serial;
   logic clk = 1'b0, reset = 1'b0, wren = 1'b0, sin_drv = 1'b1, loop = 1'b0, sclk_ext = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0] data_i = 8'h00, data_o, tx_data, e;
   logic sin, sout, sclk_out, irq_serial, tx_strobe;
   int total = 0, bad = 0, n, irqs;
   assign sin = loop ? sout : sin_drv;
   always #5 clk = ~clk;
   gb_serial #(.CLKS_PER_BIT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .data_i    (data_i),
      .wren      (wren),
      .data_o    (data_o),
      .sin       (sin),
      .sclk_ext  (sclk_ext),
      .sout      (sout),
      .sclk_out  (sclk_out),
      .irq_serial(irq_serial),
      .tx_strobe (tx_strobe),
      .tx_data   (tx_data)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; data_i = d; wren = 1'b1;
      tick;
      wren = 1'b0; addr = 16'h0000;
   endtask
   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      chk(tag, data_o, exp);
      addr = 16'h0000;
   endtask
   task automatic wait_irq(input int limit, output int cycles);
      cycles = 0;
      while (!irq_serial && cycles < limit) begin
         tick;
         cycles++;
      end
   endtask
   initial begin
      // reset state
      tick; tick;
      chk("rst_sout", sout, 1);
      chk("rst_sclk", sclk_out, 1);
      chk("rst_irq", irq_serial, 0);
      chk("rst_strobe", tx_strobe, 0);
      chk("rst_txdata", tx_data, 8'h00);
      rd("rst_sb", 16'hFF01, 8'h00);
      rd("rst_sc", 16'hFF02, 8'h7E);
      rd("rst_other", 16'hFF00, 8'hFF);
      reset = 1'b1;
      tick;
      // internal transfer of 0x41 with sin=1
      wr(16'hFF01, 8'h41);
      wr(16'hFF02, 8'h81);
      chk("start_strobe", tx_strobe, 1);
      chk("start_txdata", tx_data, 8'h41);
      for (int i = 0; i < 32; i++) begin
         if (i % 4 == 0) begin
            chk("int_sout", sout, (8'h41 >> (7 - i / 4)) & 1);
            chk("int_sclk_lo", sclk_out, 0);
         end
         if (i % 4 == 2) chk("int_sclk_hi", sclk_out, 1);
         if (i == 1) chk("strobe_once", tx_strobe, 0);
         chk("int_irq_early", irq_serial, 0);
         tick;
      end
      chk("int_irq", irq_serial, 1);
      rd("int_sc_done", 16'hFF02, 8'h7F);
      rd("int_sb_done", 16'hFF01, 8'hFF);
      chk("int_sout_hold", sout, 1);
      tick;
      chk("int_irq_pulse", irq_serial, 0);
      // loopback rotates the byte back into place
      loop = 1'b1;
      wr(16'hFF01, 8'hA5);
      wr(16'hFF02, 8'h81);
      wait_irq(40, n);
      chk("lb_latency", n, 32);
      rd("lb_sb", 16'hFF01, 8'hA5);
      loop = 1'b0;
      tick;
      // external clock: nothing moves without edges
      sin_drv = 1'b0;
      wr(16'hFF01, 8'h3C);
      wr(16'hFF02, 8'h80);
      repeat (20) tick;
      rd("ext_noedge_sb", 16'hFF01, 8'h3C);
      rd("ext_busy_sc", 16'hFF02, 8'hFE);
      chk("ext_sclk", sclk_out, 1);
      e = 8'h3C;
      for (int k = 0; k < 8; k++) begin
         sclk_ext = 1'b1;
         tick; tick;
         rd("ext_before", 16'hFF01, e);
         chk("ext_irq_early", irq_serial, 0);
         tick;
         e = e << 1;
         rd("ext_shift", 16'hFF01, e);
         chk("ext_irq", irq_serial, k == 7);
         sclk_ext = 1'b0;
         tick; tick; tick;
      end
      rd("ext_final_sb", 16'hFF01, 8'h00);
      rd("ext_final_sc", 16'hFF02, 8'h7E);
      chk("ext_irq_gone", irq_serial, 0);
      // abort after two internal shifts: 0x41 -> 0x83 -> 0x07 with sin=1
      sin_drv = 1'b1;
      wr(16'hFF01, 8'h41);
      wr(16'hFF02, 8'h81);
      repeat (9) tick;
      wr(16'hFF02, 8'h01);
      irqs = 0;
      repeat (40) begin
         irqs += irq_serial;
         tick;
      end
      chk("abort_irq", irqs, 0);
      rd("abort_sc", 16'hFF02, 8'h7F);
      rd("abort_sb", 16'hFF01, 8'h07);
      // SB write colliding with a shift, then restart
      wr(16'hFF01, 8'h41);
      wr(16'hFF02, 8'h81);
      repeat (3) tick;
      wr(16'hFF01, 8'h5A);
      rd("collide_sb", 16'hFF01, 8'h5A);
      tick; tick;
      wr(16'hFF02, 8'h81);
      chk("restart_strobe", tx_strobe, 1);
      chk("restart_txdata", tx_data, 8'h5A);
      wait_irq(40, n);
      chk("restart_latency", n, 32);
      rd("restart_sb", 16'hFF01, 8'hFF);
      tick;
      // reset mid-transfer
      wr(16'hFF01, 8'h41);
      wr(16'hFF02, 8'h81);
      repeat (5) tick;
      chk("pre_rst_sclk", sclk_out, 0);
      reset = 1'b0;
      tick;
      chk("mid_rst_sout", sout, 1);
      chk("mid_rst_sclk", sclk_out, 1);
      chk("mid_rst_irq", irq_serial, 0);
      chk("mid_rst_strobe", tx_strobe, 0);
      chk("mid_rst_txdata", tx_data, 8'h00);
      rd("mid_rst_sb", 16'hFF01, 8'h00);
      rd("mid_rst_sc", 16'hFF02, 8'h7E);
      rd("mid_rst_other", 16'h1234, 8'hFF);
      reset = 1'b1;
      irqs = 0;
      repeat (40) begin
         irqs += irq_serial;
         tick;
      end
      chk("post_rst_irq", irqs, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
